// File: rtl/npc_seq_ctrl.sv
// npc_seq_ctrl: multi-cycle sequencer for the NPC core.
// Fetches one instruction at a time, holds it stable for the combinational
// decode/execute datapath, qualifies the single write-back cycle, steps the
// PC (sequential, JAL, JALR) and stops for good on ebreak, an unsupported
// opcode or a fetch that never gets answered.
module npc_seq_ctrl #(
  parameter logic [31:0] RESET_PC      = 32'h8000_0000,
  parameter int unsigned FETCH_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req_valid,
  output logic [31:0] ifu_req_addr,
  input  logic        ifu_req_ready,
  input  logic        ifu_rsp_valid,
  input  logic [31:0] ifu_rsp_data,
  output logic [31:0] inst,
  output logic [31:0] pc,
  input  logic [31:0] dec_imm,
  input  logic        dec_reg_write,
  input  logic [31:0] alu_result,
  output logic        rf_wen,
  output logic        wb_pc4,
  output logic [31:0] pc_plus4,
  output logic        halted,
  output logic [1:0]  halt_code,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    EXEC  = 3'd3,
    WB    = 3'd4,
    HALT  = 3'd5
  } state_e;

  // Supported major opcodes; anything else stops the core as illegal.
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [31:0] Ebreak  = 32'h0010_0073;

  localparam logic [1:0] CodeEbreak  = 2'd0;
  localparam logic [1:0] CodeIllegal = 2'd1;
  localparam logic [1:0] CodeTimeout = 2'd2;

  // Last WAIT count value before giving up on the memory.
  localparam logic [7:0] TimeoutLast = 8'(FETCH_TIMEOUT - 1);

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [7:0]  wait_cnt_q;
  logic [31:0] instret_q;
  logic        halted_q;
  logic [1:0]  halt_code_q;
  logic        req_valid_q;
  logic        wb_q;
  logic        wb_pc4_q;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_jal;
  logic        is_jalr;
  logic        is_ebreak;
  logic        is_legal;
  logic [31:0] pc_plus4_d;
  logic [31:0] npc_d;

  // Classify the latched instruction; it is stable from EXEC through WB.
  always_comb begin
    opcode    = inst_q[6:0];
    funct3    = inst_q[14:12];
    is_jal    = (opcode == OpJal);
    is_jalr   = (opcode == OpJalr) && (funct3 == 3'b000);
    is_ebreak = (inst_q == Ebreak);
    is_legal  = (opcode == OpLui) || (opcode == OpAuipc) ||
                ((opcode == OpOpImm) && (funct3 == 3'b000)) ||
                is_jal || is_jalr;
  end

  // Next-PC selection used when the WB cycle retires the instruction.
  always_comb begin
    pc_plus4_d = pc_q + 32'd4;
    npc_d      = pc_plus4_d;
    if (is_jal) begin
      npc_d = pc_q + dec_imm;
    end else if (is_jalr) begin
      npc_d = {alu_result[31:1], 1'b0};
    end
  end

  // Sequencer FSM; every strobe is registered so it lines up with its state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      inst_q      <= '0;
      wait_cnt_q  <= '0;
      instret_q   <= '0;
      halted_q    <= 1'b0;
      halt_code_q <= CodeEbreak;
      req_valid_q <= 1'b0;
      wb_q        <= 1'b0;
      wb_pc4_q    <= 1'b0;
    end else begin
      req_valid_q <= 1'b0;
      wb_q        <= 1'b0;
      wb_pc4_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          state_q     <= FETCH;
          req_valid_q <= 1'b1;
        end
        FETCH: begin
          if (ifu_req_ready) begin
            state_q    <= WAIT;
            wait_cnt_q <= '0;
          end else begin
            req_valid_q <= 1'b1;
          end
        end
        WAIT: begin
          if (ifu_rsp_valid) begin
            inst_q  <= ifu_rsp_data;
            state_q <= EXEC;
          end else if (wait_cnt_q == TimeoutLast) begin
            state_q     <= HALT;
            halted_q    <= 1'b1;
            halt_code_q <= CodeTimeout;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        EXEC: begin
          if (is_ebreak) begin
            state_q     <= HALT;
            halted_q    <= 1'b1;
            halt_code_q <= CodeEbreak;
          end else if (!is_legal) begin
            state_q     <= HALT;
            halted_q    <= 1'b1;
            halt_code_q <= CodeIllegal;
          end else begin
            state_q  <= WB;
            wb_q     <= 1'b1;
            wb_pc4_q <= is_jal || is_jalr;
          end
        end
        WB: begin
          pc_q        <= npc_d;
          instret_q   <= instret_q + 32'd1;
          state_q     <= FETCH;
          req_valid_q <= 1'b1;
        end
        HALT: begin
          state_q <= HALT;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ifu_req_valid = req_valid_q;
  assign ifu_req_addr  = pc_q;
  assign inst          = inst_q;
  assign pc            = pc_q;
  assign pc_plus4      = pc_plus4_d;
  assign rf_wen        = wb_q & dec_reg_write;
  assign wb_pc4        = wb_pc4_q;
  assign halted        = halted_q;
  assign halt_code     = halt_code_q;
  assign instret       = instret_q;

endmodule
